mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the 5-stage pipeline; consumes the EX/MEM register outputs (aluout, WriteDataM, writereg, pcEM).
- Performs loads/stores to the data memory through a req/ready handshake with variable wait states. Stalls upstream during accesses.
- Registers results into the MEM/WB boundary for the writeback stage.

Parameters:
- MAX_WAIT, 16: max ACCESS cycles without dmem_ready before a bus error (range 1..255).
- WAIT_W, 8: width of the wait counter.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- validM  in  1  EX/MEM slot holds a real instruction
- memreadM  in  1  load
- memwriteM  in  1  store
- regwriteM  in  1  instruction writes rd
- memtoregM  in  1  writeback selects load data
- sizeM  in  2  00 byte, 01 half, 10/11 word
- unsignedM  in  1  zero-extend loads (lbu/lhu)
- aluout  in  32  effective address / ALU result
- WriteDataM  in  32  store data
- writereg  in  5  destination register
- pcEM  in  32  instruction PC
- dmem_req  out  1  access request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address {aluout[31:2],2'b00}
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ready  in  1  access complete this cycle
- dmem_rdata  in  32  read word, valid with dmem_ready
- stallM  out  1  hold EX/MEM and earlier stages
- validW  out  1  MEM/WB slot valid
- regwriteW  out  1  registered write enable
- memtoregW  out  1  registered select
- readdataW  out  32  extended load data
- aluoutW  out  32  registered ALU result
- writeregW  out  5  registered destination
- pcMW  out  32  registered PC
- berrW  out  1  access timed out

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, wait counter=0, all MEM/WB outputs 0.
  - dmem_req=0 immediately; this aborts any in-flight access with no writeback.
- FSM states: IDLE, ACCESS.
- memop = validM & (memreadM | memwriteM).
- IDLE:
  - If memop: go to ACCESS at the next edge. MEM/WB outputs load a bubble (validW=0, regwriteW=0).
  - If not memop: MEM/WB outputs load from inputs every edge (latency 1). validW=validM, berrW=0, readdataW=0.
- ACCESS:
  - dmem_req=1.
  - dmem_we, addr, wdata and be are derived combinationally from the held inputs.
  - The wait counter increments each cycle without ready.
- Completion in ACCESS:
  - On dmem_ready: MEM/WB outputs load from inputs, readdataW = extracted load data (0 for stores), validW=1, counter cleared, return to IDLE.
  - Timeout: the counter reaches MAX_WAIT-1 without ready. Drop req, validW=1, regwriteW=0, berrW=1, return to IDLE.
  - If ready and timeout occur in the same cycle, ready wins.
- stallM = memop & ~(state==ACCESS & (dmem_ready | timeout)), combinational. Upstream must hold all inputs stable while stallM=1.
- Minimum memop latency is 2 cycles: the IDLE cycle plus one ACCESS cycle with ready.
- Store byte enables and data:
  - Byte: be = 0001<<addr[1:0], wdata = {4{data[7:0]}}.
  - Half: be = 0011<<{addr[1],1'b0}, wdata = {2{data[15:0]}}.
  - Word: be = 1111.
- Load extraction: select the byte/half lane by addr[1:0], then sign-extend or zero-extend per unsignedM.
- Without the optional feature, addr[0] is ignored for halves and addr[1:0] for words.
- dmem_be is 0 when dmem_req=0.

Optional Feature:
- Macro MEM_MISALIGN_TRAP_EN.
- Defined:
  - A memop that is a half access with addr[0]=1, or a word access with addr[1:0]!=0, issues no access. It stays in IDLE.
  - Next edge: validW=1, regwriteW=0, plus extra outputs misalignW=1 and badaddrW=aluout.
  - stallM=0 for that instruction.
- Undefined: no extra ports; low address bits are forced as above and the access proceeds.

Decomposition:
- Shared package mem_pkg: size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), FSM state typedef, MAX_WAIT default.
- One natural sub-module: mem_lane_align. It is purely combinational and generates store be/wdata plus the load extract/extend. It can be reused by a future instruction-fetch aligner.

Test Plan:
- Non-mem ALU op: validM=1, aluout=0x1234, writereg=5 -> next edge aluoutW=0x1234, writeregW=5, validW=1, stallM never asserted.
- lw at 0x100, ready after 3 ACCESS cycles, rdata=0xDEADBEEF -> stallM high 4 cycles, then readdataW=0xDEADBEEF, validW=1.
- lb at 0x103, rdata=0x80000000 -> readdataW=0xFFFFFF80. lbu at the same address -> 0x00000080.
- sh at 0x102, data=0xABCD -> dmem_we=1, be=1100, wdata=0xABCDABCD, regwriteW=0.
- No ready for MAX_WAIT=16 cycles -> req drops, berrW=1, regwriteW=0, stallM released. Ready on the 16th cycle instead -> normal completion, berrW=0.
- rst_n pulled low mid-ACCESS -> dmem_req=0 asynchronously, all outputs 0. After release, the next instruction proceeds normally.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared definitions for the memory stage.
//   - Access size encodings (SZ_BYTE, SZ_HALF, SZ_WORD; 2'b11 also decodes as word).
//   - FSM state type for the access sequencer.
//   - Default bus-error timeout (MAX_WAIT_DEFAULT).
//   - is_misaligned(): natural-alignment test used when MEM_MISALIGN_TRAP_EN is defined.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned MAX_WAIT_DEFAULT = 16;

  typedef enum logic {
    StIdle,
    StAccess
  } mem_state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    if (size == SZ_BYTE) begin
      mis = 1'b0;
    end else if (size == SZ_HALF) begin
      mis = addr_lo[0];
    end else begin
      mis = (addr_lo != 2'b00);
    end
    return mis;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for a 32-bit data bus.
//   size_i        access size (mem_pkg SZ_* encoding)
//   addr_lo_i     address bits [1:0]
//   st_data_i     store data (LSB-justified)
//   st_be_o       store byte enables
//   st_wdata_o    lane-replicated store data
//   ld_word_i     raw read word from memory
//   ld_unsigned_i 1 = zero-extend, 0 = sign-extend
//   ld_data_o     extracted and extended load data
// Halves ignore addr_lo_i[0] and words ignore addr_lo_i entirely.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  st_be_o,
  output logic [31:0] st_wdata_o,
  input  logic [31:0] ld_word_i,
  input  logic        ld_unsigned_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    ld_byte = ld_word_i[7:0];
    case (addr_lo_i)
      2'b00:   ld_byte = ld_word_i[7:0];
      2'b01:   ld_byte = ld_word_i[15:8];
      2'b10:   ld_byte = ld_word_i[23:16];
      default: ld_byte = ld_word_i[31:24];
    endcase
    ld_half = addr_lo_i[1] ? ld_word_i[31:16] : ld_word_i[15:0];
  end

  always_comb begin
    st_be_o    = 4'b1111;
    st_wdata_o = st_data_i;
    ld_data_o  = ld_word_i;
    case (size_i)
      SZ_BYTE: begin
        st_be_o    = 4'b0001 << addr_lo_i;
        st_wdata_o = {4{st_data_i[7:0]}};
        ld_data_o  = ld_unsigned_i ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      end
      SZ_HALF: begin
        st_be_o    = 4'b0011 << {addr_lo_i[1], 1'b0};
        st_wdata_o = {2{st_data_i[15:0]}};
        ld_data_o  = ld_unsigned_i ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
      end
      default: begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_data_i;
        ld_data_o  = ld_word_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage. Takes the EX/MEM slot, performs loads/stores over a
// req/ready data-memory bus with a wait-state timeout, and registers the MEM/WB slot.
//   Inputs : validM, memreadM, memwriteM, regwriteM, memtoregM, sizeM, unsignedM,
//            aluout, WriteDataM, writereg, pcEM, dmem_ready, dmem_rdata
//   Bus    : dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be
//   Control: stallM holds upstream while an access is outstanding
//   MEM/WB : validW, regwriteW, memtoregW, readdataW, aluoutW, writeregW, pcMW, berrW
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses are not issued and
// instead report misalignW/badaddrW in the MEM/WB slot.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              validM,
  input  logic              memreadM,
  input  logic              memwriteM,
  input  logic              regwriteM,
  input  logic              memtoregM,
  input  logic [1:0]        sizeM,
  input  logic              unsignedM,
  input  logic [31:0]       aluout,
  input  logic [31:0]       WriteDataM,
  input  logic [4:0]        writereg,
  input  logic [31:0]       pcEM,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [31:0]       dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ready,
  input  logic [31:0]       dmem_rdata,
  output logic              stallM,
  output logic              validW,
  output logic              regwriteW,
  output logic              memtoregW,
  output logic [31:0]       readdataW,
  output logic [31:0]       aluoutW,
  output logic [4:0]        writeregW,
  output logic [31:0]       pcMW,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic              misalignW,
  output logic [31:0]       badaddrW,
`endif
  output logic              berrW
);

  mem_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic        valid_q, valid_d;
  logic        regwrite_q, regwrite_d;
  logic        memtoreg_q, memtoreg_d;
  logic [31:0] readdata_q, readdata_d;
  logic [31:0] alu_q, alu_d;
  logic [4:0]  wreg_q, wreg_d;
  logic [31:0] pc_q, pc_d;
  logic        berr_q, berr_d;

  logic        memop, access_op, in_access, timeout, done;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_ld;

`ifdef MEM_MISALIGN_TRAP_EN
  logic        misal;
  logic        misal_q, misal_d;
  logic [31:0] badaddr_q, badaddr_d;
  assign misal = memop & is_misaligned(sizeM, aluout[1:0]);
`endif

  assign memop = validM & (memreadM | memwriteM);
`ifdef MEM_MISALIGN_TRAP_EN
  assign access_op = memop & ~misal;
`else
  assign access_op = memop;
`endif

  assign in_access = (state_q == StAccess);
  // Ready on the last allowed cycle takes priority over the timeout.
  assign timeout   = in_access & ~dmem_ready & (wait_q == WAIT_W'(MAX_WAIT - 1));
  assign done      = in_access & (dmem_ready | timeout);
  assign stallM    = access_op & ~done;

  mem_lane_align u_lane_align (
    .size_i        (sizeM),
    .addr_lo_i     (aluout[1:0]),
    .st_data_i     (WriteDataM),
    .st_be_o       (lane_be),
    .st_wdata_o    (lane_wdata),
    .ld_word_i     (dmem_rdata),
    .ld_unsigned_i (unsignedM),
    .ld_data_o     (lane_ld)
  );

  // Bus is driven straight from the held EX/MEM inputs; req comes from state only, so an
  // asynchronous reset drops it immediately.
  assign dmem_req   = in_access;
  assign dmem_we    = in_access & memwriteM;
  assign dmem_addr  = {aluout[31:2], 2'b00};
  assign dmem_wdata = lane_wdata;
  assign dmem_be    = in_access ? lane_be : 4'b0000;

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    // Default: slot loads straight from the EX/MEM inputs.
    valid_d    = validM;
    regwrite_d = regwriteM;
    memtoreg_d = memtoregM;
    readdata_d = 32'b0;
    alu_d      = aluout;
    wreg_d     = writereg;
    pc_d       = pcEM;
    berr_d     = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    misal_d    = 1'b0;
    badaddr_d  = 32'b0;
`endif
    case (state_q)
      StIdle: begin
        if (access_op) begin
          state_d    = StAccess;
          wait_d     = '0;
          valid_d    = 1'b0;
          regwrite_d = 1'b0;
          memtoreg_d = 1'b0;
          alu_d      = 32'b0;
          wreg_d     = 5'b0;
          pc_d       = 32'b0;
        end
`ifdef MEM_MISALIGN_TRAP_EN
        else if (misal) begin
          valid_d    = 1'b1;
          regwrite_d = 1'b0;
          misal_d    = 1'b1;
          badaddr_d  = aluout;
        end
`endif
      end
      default: begin
        if (dmem_ready) begin
          state_d    = StIdle;
          wait_d     = '0;
          valid_d    = 1'b1;
          readdata_d = memreadM ? lane_ld : 32'b0;
        end else if (timeout) begin
          state_d    = StIdle;
          wait_d     = '0;
          valid_d    = 1'b1;
          regwrite_d = 1'b0;
          berr_d     = 1'b1;
        end else begin
          wait_d     = wait_q + WAIT_W'(1);
          valid_d    = valid_q;
          regwrite_d = regwrite_q;
          memtoreg_d = memtoreg_q;
          readdata_d = readdata_q;
          alu_d      = alu_q;
          wreg_d     = wreg_q;
          pc_d       = pc_q;
          berr_d     = berr_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wait_q     <= '0;
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      readdata_q <= 32'b0;
      alu_q      <= 32'b0;
      wreg_q     <= 5'b0;
      pc_q       <= 32'b0;
      berr_q     <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misal_q    <= 1'b0;
      badaddr_q  <= 32'b0;
`endif
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      valid_q    <= valid_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      readdata_q <= readdata_d;
      alu_q      <= alu_d;
      wreg_q     <= wreg_d;
      pc_q       <= pc_d;
      berr_q     <= berr_d;
`ifdef MEM_MISALIGN_TRAP_EN
      misal_q    <= misal_d;
      badaddr_q  <= badaddr_d;
`endif
    end
  end

  assign validW    = valid_q;
  assign regwriteW = regwrite_q;
  assign memtoregW = memtoreg_q;
  assign readdataW = readdata_q;
  assign aluoutW   = alu_q;
  assign writeregW = wreg_q;
  assign pcMW      = pc_q;
  assign berrW     = berr_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misalignW = misal_q;
  assign badaddrW  = badaddr_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: randomized scoreboard bench for mem_stage (default build, 16 wait cycles).
module tb_mem_stage;

  localparam int MW = 16;

  logic        clk, rst_n;
  logic        validM, memreadM, memwriteM, regwriteM, memtoregM, unsignedM;
  logic [1:0]  sizeM;
  logic [31:0] aluout, WriteDataM, pcEM;
  logic [4:0]  writereg;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        stallM, validW, regwriteW, memtoregW, berrW;
  logic [31:0] readdataW, aluoutW, pcMW;
  logic [4:0]  writeregW;

  mem_stage #(.MAX_WAIT(MW), .WAIT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .validM     (validM),
    .memreadM   (memreadM),
    .memwriteM  (memwriteM),
    .regwriteM  (regwriteM),
    .memtoregM  (memtoregM),
    .sizeM      (sizeM),
    .unsignedM  (unsignedM),
    .aluout     (aluout),
    .WriteDataM (WriteDataM),
    .writereg   (writereg),
    .pcEM       (pcEM),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_be    (dmem_be),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .stallM     (stallM),
    .validW     (validW),
    .regwriteW  (regwriteW),
    .memtoregW  (memtoregW),
    .readdataW  (readdataW),
    .aluoutW    (aluoutW),
    .writeregW  (writeregW),
    .pcMW       (pcMW),
    .berrW      (berrW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        regwrite;
    logic        memtoreg;
    logic        berr;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [4:0]  wr;
  } exp_t;

  exp_t sb[$];

  // Reference model: lane arithmetic straight from the size/offset rules.
  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic [31:0] addr,
                                           input logic [31:0] word, input logic uns);
    int unsigned off;
    logic [31:0] v;
    off = addr % 4;
    if (sz == 2'd0) begin
      v = (word >> (8 * off)) & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      off = off & 2;
      v = (word >> (8 * off)) & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [31:0] addr);
    int unsigned m;
    if (sz == 2'd0) m = 1 << (addr % 4);
    else if (sz == 2'd1) m = 3 << (addr & 2);
    else m = 15;
    return 4'(m);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2'd1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  // Monitor: every valid MEM/WB slot must match the head of the scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n && validW) begin
      if (sb.size() == 0) begin
        chk("unexpected_validW", 32'(validW), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("regwriteW", 32'(regwriteW), 32'(e.regwrite));
        chk("berrW", 32'(berrW), 32'(e.berr));
        if (!e.berr) begin
          chk("readdataW", readdataW, e.rdata);
          chk("aluoutW", aluoutW, e.alu);
          chk("writeregW", 32'(writeregW), 32'(e.wr));
          chk("pcMW", pcMW, e.pc);
          chk("memtoregW", 32'(memtoregW), 32'(e.memtoreg));
        end
      end
    end
  end

  // Issues one EX/MEM slot (call at a negedge) and acts as the memory.
  // wait_n: ACCESS cycles without ready before ready; >= MW means never (timeout).
  task automatic run_txn(input logic v, input logic rd, input logic wr, input logic rw,
                         input logic m2r, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rdst, input logic [31:0] pc, input int wait_n,
                         input bit fix_rd, input logic [31:0] rfix);
    int acc = 0;
    int stalls = 0;
    int exp_stall;
    bit done = 0;
    bit memop;
    logic [31:0] rword = 32'b0;
    exp_t e;
    validM = v; memreadM = rd; memwriteM = wr; regwriteM = rw; memtoregM = m2r;
    sizeM = sz; unsignedM = uns; aluout = addr; WriteDataM = data; writereg = rdst;
    pcEM = pc;
    memop = v & (rd | wr);
    exp_stall = !memop ? 0 : (wait_n >= MW ? MW : 1 + wait_n);
    for (int c = 0; c < 40 && !done; c++) begin
      dmem_ready = dmem_req && (acc == wait_n);
      rword = fix_rd ? rfix : $urandom;
      dmem_rdata = rword;
      #1;
      if (dmem_req && acc == 0) begin
        chk("dmem_we", 32'(dmem_we), 32'(wr));
        chk("dmem_addr", dmem_addr, addr & 32'hFFFF_FFFC);
        if (wr) begin
          chk("dmem_be", 32'(dmem_be), 32'(ref_be(sz, addr)));
          chk("dmem_wdata", dmem_wdata, ref_wdata(sz, data));
        end
      end
      if (stallM) stalls++;
      else done = 1;
      if (dmem_req) acc++;
      if (!done) @(negedge clk);
    end
    if (!done) chk("stall_bound", 32'd0, 32'd1);
    chk("stall_cycles", 32'(stalls), 32'(exp_stall));
    if (v) begin
      e.berr     = memop && (wait_n >= MW);
      e.regwrite = e.berr ? 1'b0 : rw;
      e.memtoreg = m2r;
      e.rdata    = (memop && rd && !e.berr) ? ref_load(sz, addr, rword, uns) : 32'b0;
      e.alu      = addr;
      e.pc       = pc;
      e.wr       = rdst;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    dmem_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; validM = 0; memreadM = 0; memwriteM = 0; regwriteM = 0; memtoregM = 0;
    sizeM = 0; unsignedM = 0; aluout = 0; WriteDataM = 0; writereg = 0; pcEM = 0;
    dmem_ready = 0; dmem_rdata = 0;
    #1;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_validW", 32'(validW), 32'd0);
    chk("rst_aluoutW", aluoutW, 32'd0);
    chk("rst_stallM", 32'(stallM), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    run_txn(1, 0, 0, 1, 0, 2'd2, 0, 32'h1234, 32'h0, 5'd5, 32'h40, 0, 0, 0);
    run_txn(1, 1, 0, 1, 1, 2'd2, 0, 32'h100, 32'h0, 5'd7, 32'h44, 3, 1, 32'hDEAD_BEEF);
    run_txn(1, 1, 0, 1, 1, 2'd0, 0, 32'h103, 32'h0, 5'd8, 32'h48, 0, 1, 32'h8000_0000);
    run_txn(1, 1, 0, 1, 1, 2'd0, 1, 32'h103, 32'h0, 5'd9, 32'h4C, 1, 1, 32'h8000_0000);
    run_txn(1, 0, 1, 0, 0, 2'd1, 0, 32'h102, 32'hABCD, 5'd0, 32'h50, 1, 0, 0);
    run_txn(1, 1, 0, 1, 1, 2'd2, 0, 32'h200, 32'h0, 5'd10, 32'h54, MW, 0, 0);
    run_txn(1, 1, 0, 1, 1, 2'd1, 0, 32'h206, 32'h0, 5'd11, 32'h58, MW - 1, 0, 0);

    // Reset in the middle of an access.
    validM = 1; memreadM = 1; memwriteM = 0; regwriteM = 1; memtoregM = 1; sizeM = 2;
    aluout = 32'h300; writereg = 5'd12; pcEM = 32'h60; dmem_ready = 0;
    repeat (3) @(negedge clk);
    chk("req_before_reset", 32'(dmem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    validM = 1'b0;
    #1;
    chk("async_req_drop", 32'(dmem_req), 32'd0);
    chk("async_be_zero", 32'(dmem_be), 32'd0);
    chk("async_validW", 32'(validW), 32'd0);
    chk("async_regwriteW", 32'(regwriteW), 32'd0);
    chk("async_readdataW", readdataW, 32'd0);
    chk("async_stallM", 32'(stallM), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_txn(1, 1, 0, 1, 1, 2'd1, 0, 32'h302, 32'h0, 5'd13, 32'h64, 2, 1, 32'h8001_7FFF);

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      int kind, r, w;
      logic v, rd, wr, rw, m2r;
      kind = $urandom_range(0, 3);
      r = $urandom_range(0, 9);
      w = (r == 0) ? MW : ((r == 1) ? MW - 1 : $urandom_range(0, 4));
      v = 1; rd = 0; wr = 0; rw = 1'($urandom_range(0, 1)); m2r = 0;
      if (kind == 1) begin rd = 1; rw = 1; m2r = 1; end
      else if (kind == 2) begin wr = 1; rw = 0; end
      else if (kind == 3) begin v = 0; rd = 1'($urandom_range(0, 1)); end
      run_txn(v, rd, wr, rw, m2r, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              $urandom, $urandom, 5'($urandom_range(0, 31)), $urandom, w, 0, 0);
    end

    validM = 1'b0;
    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
